// File: rtl/dram_arbiter.sv
// Two-master round-robin arbiter and RMW sequencer for a single-port, full-word-write data RAM.
// Latency: read / full write 2 cycles (IDLE + ACCESS), partial byte-enable write 3 cycles.
// Backpressure: mN_waitrequest holds each master until its access completes; optional macro DRAM_ARB_FIXED_PRIO_EN.
module dram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    output logic                    m0_waitrequest,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    output logic                    m1_waitrequest,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_writedata,
    input  logic [DATA_WIDTH-1:0]   mem_readdata
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
    logic                    last_grant_q, last_grant_d;
`endif

    logic                    m0_req, m1_req;
    logic                    grant_pick;
    logic                    done;
    logic [ADDR_WIDTH-1:0]   g_addr;
    logic                    g_rd, g_wr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic [NB-1:0]           g_be;

    // Request decode and mux of the granted master's command
    always_comb begin
        m0_req  = m0_read | m0_write;
        m1_req  = m1_read | m1_write;
        g_addr  = grant_q ? m1_address   : m0_address;
        g_rd    = grant_q ? m1_read      : m0_read;
        g_wr    = grant_q ? m1_write     : m0_write;
        g_wdata = grant_q ? m1_writedata : m0_writedata;
        g_be    = grant_q ? m1_byteenable : m0_byteenable;
    end

    // Arbitration choice made in IDLE (round robin by default, m0-first when fixed priority)
    always_comb begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
        grant_pick = m0_req ? 1'b0 : 1'b1;
`else
        if (m0_req && m1_req) begin
            grant_pick = ~last_grant_q;
        end else begin
            grant_pick = m1_req;
        end
`endif
    end

    // Sequencer: next state, RAM command and per-master completion
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        merge_d       = merge_q;
        mem_address   = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = grant_pick;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_address = g_addr & ~ADDR_WIDTH'(3);
                state_d     = IDLE;
                if (g_wr) begin
                    if (g_be == {NB{1'b1}}) begin
                        mem_write     = 1'b1;
                        mem_writedata = g_wdata;
                        done          = 1'b1;
                    end else if (g_be == '0) begin
                        done = 1'b1;
                    end else begin
                        // Partial write: fetch the old word and merge enabled lanes over it
                        mem_read = 1'b1;
                        for (int i = 0; i < NB; i++) begin
                            merge_d[8*i +: 8] = g_be[i] ? g_wdata[8*i +: 8] : mem_readdata[8*i +: 8];
                        end
                        state_d = RMW_WR;
                    end
                end else if (g_rd) begin
                    mem_read = 1'b1;
                    done     = 1'b1;
                end
            end
            RMW_WR: begin
                mem_address   = g_addr & ~ADDR_WIDTH'(3);
                mem_write     = 1'b1;
                mem_writedata = merge_q;
                done          = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A reset cycle never touches the RAM and never completes a transaction
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            done      = 1'b0;
        end
    end

    // Read-data capture and round-robin history, updated only on completion
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (done && mem_read && !grant_q) rdata0_d = mem_readdata;
        if (done && mem_read &&  grant_q) rdata1_d = mem_readdata;
`ifndef DRAM_ARB_FIXED_PRIO_EN
        last_grant_d = done ? grant_q : last_grant_q;
`endif
    end

    // Master-facing handshake; read data is live in the completing cycle and held afterwards
    always_comb begin
        m0_waitrequest = m0_req & ~(done & ~grant_q);
        m1_waitrequest = m1_req & ~(done &  grant_q);
        m0_readdata    = rdata0_d;
        m1_readdata    = rdata1_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            merge_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            merge_q      <= merge_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule
